mem_arbiter: RTL
================

# mem_arbiter

Single-owner controller for the shared multicycle main memory: it arbitrates between the instruction-cache miss path (I) and the data-cache miss/write path (D). It sequences each 8-word block fill as back-to-back pipelined reads and each store as a single write. It sits between both cache controllers and the main memory in the cpu, replacing direct memory hookups.

## Interface
- MEM_LAT, 4, cycles from a read issue to its mem_valid (≥2)
- ADDR_W, 16, address width; words are 16-bit, byte-addressed
- clk  in  1  clock, all state updates on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- i_req  in  1  I-side block-fill request, held until i_done
- i_addr  in  16  I miss address; bits [3:0] ignored
- d_req  in  1  D-side request, held until d_done
- d_wr  in  1  D-side: 1 = single-word write, 0 = block fill
- d_addr  in  16  D address; for fills bits [3:0] ignored, for writes used whole
- d_wdata  in  16  D write data
- i_grant / d_grant  out  1  high for every cycle the side owns memory
- i_fill_valid / d_fill_valid  out  1  fill_data is a valid word for that side
- fill_idx  out  3  word index (0..7) of current fill_data
- fill_data  out  16  returned word (mem_rdata passthrough)
- i_done / d_done  out  1  one-cycle completion pulse
- busy  out  1  state != IDLE
- mem_en, mem_wr  out  1  memory enable / write
- mem_addr  out  16  memory address
- mem_wdata  out  16  memory write data
- mem_rdata  in  16  memory read data
- mem_valid  in  1  mem_rdata valid this cycle

## Operation
- States: IDLE, FILL_I, FILL_D, WRITE.
- IDLE: only i_req alone → FILL_I; only d_req alone → (d_wr ? WRITE : FILL_D); both → side not served last (last flag resets to "I", so D wins first contest); d_wr sampled with the grant decision.
- On leaving IDLE: latch base = addr[15:4] of granted side, plus d_wdata for WRITE; zero issue counter (4 bits) and rx counter (3 bits).
- FILL_x: while issue counter < 8: mem_en=1, mem_wr=0, mem_addr={base, issue[2:0], 1'b0}, issue increments. Afterward mem_en=0.
- FILL_x: each mem_valid → x_fill_valid=1, fill_idx=rx, rx increments (wraps to 0 after 7). mem_valid with rx==7 → x_done=1 same cycle, last←x, next state IDLE.
- WRITE: one cycle; mem_en=1, mem_wr=1, mem_addr=latched d_addr, mem_wdata=latched d_wdata, d_done=1, last←D, next IDLE.
- Grants are state decodes: i_grant=(FILL_I), d_grant=(FILL_D|WRITE).
- No preemption: a started transaction always completes; deasserting req mid-transaction is ignored.
- mem_valid in IDLE or WRITE ignored (no fill_valid, no counter change).
- mem_wdata = 0 and mem_addr = 0 whenever mem_en=0.

## Timing
- Reset (asynchronous, any cycle incl. mid-fill): state IDLE, counters 0, last=I, latched regs 0; all outputs 0 immediately. Post-reset in-flight mem_valid ignored.
- Request → grant: req high at edge N in IDLE → grant from cycle N+1.
- Fill, grant cycle G: reads issued cycles G..G+7; word k returns cycle G+k+MEM_LAT; done at G+7+MEM_LAT; state IDLE at G+8+MEM_LAT. MEM_LAT=4: 12 granted cycles.
- Write: 1 granted cycle, d_done in it.
- Minimum one IDLE cycle between transactions; a requester held high is regranted no earlier than 1 cycle after its done.
- fill_data, fill_valid, done combinational from mem_valid/mem_rdata and state; everything else registered.

## Test plan
- I fill alone, i_addr=0x1234, MEM_LAT=4 → mem_addr 0x1230,0x1232..0x123E in cycles G..G+7; i_fill_valid with fill_idx 0..7 in G+4..G+11; i_done at G+11 only; busy low at G+12.
- D write d_addr=0x0042, d_wdata=0xBEEF → one cycle mem_en=1, mem_wr=1, addr 0x0042, data 0xBEEF, d_done same cycle; no fill_valid.
- i_req and d_req (fill) rise together after reset → D served first; I granted in cycle after D returns to IDLE; a third contest with both held → D again.
- i_req dropped at G+2 → fill still issues all 8 reads and pulses i_done at G+11.
- rst_n low at G+5 of a D fill → all outputs 0 asynchronously; mem_valid pulses after release produce no fill_valid and busy stays 0.
- d_req asserted during I fill → d_grant stays 0 until I done; D granted first cycle after the IDLE cycle; stray mem_valid in IDLE ignored.

Source files
------------

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - I/D cache arbiter for shared main memory: 8-word pipelined block fills and single-word writes
module mem_arbiter #(
    parameter int MEM_LAT = 4,
    parameter int ADDR_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic              d_req,
    input  logic              d_wr,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [15:0]       d_wdata,
    output logic              i_grant,
    output logic              d_grant,
    output logic              i_fill_valid,
    output logic              d_fill_valid,
    output logic [2:0]        fill_idx,
    output logic [15:0]       fill_data,
    output logic              i_done,
    output logic              d_done,
    output logic              busy,
    output logic              mem_en,
    output logic              mem_wr,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [15:0]       mem_wdata,
    input  logic [15:0]       mem_rdata,
    input  logic              mem_valid
);
    typedef enum logic [1:0] {IDLE, FILL_I, FILL_D, WRITE} state_e;

    localparam logic SIDE_I = 1'b0;
    localparam logic SIDE_D = 1'b1;

    state_e            state_q, state_d;
    logic              last_q, last_d;
    logic [ADDR_W-5:0] base_q, base_d;
    logic [ADDR_W-1:0] waddr_q, waddr_d;
    logic [15:0]       wdata_q, wdata_d;
    logic [3:0]        issue_q, issue_d;
    logic [2:0]        rx_q, rx_d;
    logic              grant_to_data;
    logic              unused_i_lo;

    assign unused_i_lo = ^i_addr[3:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            last_q  <= SIDE_I;
            base_q  <= '0;
            waddr_q <= '0;
            wdata_q <= '0;
            issue_q <= '0;
            rx_q    <= '0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            base_q  <= base_d;
            waddr_q <= waddr_d;
            wdata_q <= wdata_d;
            issue_q <= issue_d;
            rx_q    <= rx_d;
        end
    end

    assign i_grant = (state_q == FILL_I);
    assign d_grant = (state_q == FILL_D) || (state_q == WRITE);
    assign busy    = (state_q != IDLE);

    // On a contest the side that was not served last wins; last starts as I so D wins first.
    assign grant_to_data = d_req && (!i_req || (last_q == SIDE_I));

    always_comb begin
        state_d      = state_q;
        last_d       = last_q;
        base_d       = base_q;
        waddr_d      = waddr_q;
        wdata_d      = wdata_q;
        issue_d      = issue_q;
        rx_d         = rx_q;
        i_fill_valid = 1'b0;
        d_fill_valid = 1'b0;
        fill_idx     = '0;
        fill_data    = '0;
        i_done       = 1'b0;
        d_done       = 1'b0;
        mem_en       = 1'b0;
        mem_wr       = 1'b0;
        mem_addr     = '0;
        mem_wdata    = '0;

        case (state_q)
            IDLE: begin
                if (i_req || d_req) begin
                    issue_d = '0;
                    rx_d    = '0;
                    if (grant_to_data) begin
                        state_d = d_wr ? WRITE : FILL_D;
                        base_d  = d_addr[ADDR_W-1:4];
                        waddr_d = d_addr;
                        wdata_d = d_wdata;
                    end else begin
                        state_d = FILL_I;
                        base_d  = i_addr[ADDR_W-1:4];
                    end
                end
            end
            FILL_I, FILL_D: begin
                // Reads go out back-to-back; responses are counted independently as they return.
                if (!issue_q[3]) begin
                    mem_en   = 1'b1;
                    mem_addr = {base_q, issue_q[2:0], 1'b0};
                    issue_d  = issue_q + 4'd1;
                end
                if (mem_valid) begin
                    i_fill_valid = (state_q == FILL_I);
                    d_fill_valid = (state_q == FILL_D);
                    fill_idx     = rx_q;
                    fill_data    = mem_rdata;
                    rx_d         = rx_q + 3'd1;
                    if (rx_q == 3'd7) begin
                        i_done  = (state_q == FILL_I);
                        d_done  = (state_q == FILL_D);
                        last_d  = (state_q == FILL_D) ? SIDE_D : SIDE_I;
                        state_d = IDLE;
                    end
                end
            end
            WRITE: begin
                mem_en    = 1'b1;
                mem_wr    = 1'b1;
                mem_addr  = waddr_q;
                mem_wdata = wdata_q;
                d_done    = 1'b1;
                last_d    = SIDE_D;
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Memory contract: every read is answered exactly MEM_LAT cycles after it is issued.
    a_mem_latency: assert property (@(posedge clk) disable iff (!rst_n)
        $past(mem_en && !mem_wr, MEM_LAT) |-> mem_valid);

endmodule
